// File: rtl/rx_link_ctrl.sv
// rx_link_ctrl: sync-word hunt, frame verification/lock and aligned word output for the serial receive path.
// Optional macro RX_LINK_AUTO_POL_EN adds lock-on to a polarity-inverted stream (pol_inv).

module rx_link_ctrl #(
  parameter logic [15:0] SYNC_WORD    = 16'hF628,
  parameter int          FRAME_WORDS  = 8,
  parameter int          VERIFY_CNT   = 3,
  parameter int          LOSS_CNT     = 2,
  parameter int          HUNT_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_vld,
  input  logic        clr_err,
  output logic [15:0] word_out,
  output logic        word_vld,
  output logic        locked,
  output logic        bias_sel,
  output logic        pol_inv,
  output logic [7:0]  err_cnt
);

  localparam int WCW = $clog2(FRAME_WORDS);
  localparam int GW  = $clog2(VERIFY_CNT + 1);
  localparam int MW  = $clog2(LOSS_CNT + 1);
  localparam int TW  = $clog2(HUNT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    sr_q, sr_d;
  logic [15:0]    word_out_q, word_out_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [GW-1:0]  good_q, good_d;
  logic [MW-1:0]  miss_q, miss_d;
  logic [TW-1:0]  tout_q, tout_d;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic           word_vld_q, word_vld_d;
  logic           locked_q, locked_d;
  logic           bias_sel_q, bias_sel_d;
  logic           pol_inv_q, pol_inv_d;

  logic [15:0]    sr_next;
  logic           sync_match, inv_match, boundary, sync_slot, drop_hunt;
  logic [WCW-1:0] word_cnt_inc;
  logic [GW-1:0]  good_inc;
  logic [MW-1:0]  miss_inc;

  assign sr_next    = {sr_q[14:0], bit_in ^ pol_inv_q};
  assign sync_match = (sr_next == SYNC_WORD);
`ifdef RX_LINK_AUTO_POL_EN
  assign inv_match  = (sr_next == ~SYNC_WORD);
`else
  assign inv_match  = 1'b0;
`endif
  assign boundary     = (bit_cnt_q == 4'd15);
  assign sync_slot    = (word_cnt_q == '0);
  assign word_cnt_inc = (word_cnt_q == WCW'(FRAME_WORDS - 1)) ? '0 : word_cnt_q + 1'b1;
  assign good_inc     = good_q + 1'b1;
  assign miss_inc     = miss_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    word_out_d = word_out_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    good_d     = good_q;
    miss_d     = miss_q;
    tout_d     = tout_q;
    err_cnt_d  = err_cnt_q;
    word_vld_d = 1'b0;
    bias_sel_d = bias_sel_q;
    pol_inv_d  = pol_inv_q;
    drop_hunt  = 1'b0;

    if (bit_vld) begin
      sr_d      = sr_next;
      bit_cnt_d = bit_cnt_q + 4'd1;
      case (state_q)
        HUNT: begin
          // A true match outranks an inverted one, and any match suppresses the timeout toggle
          if (sync_match || inv_match) begin
            if (!sync_match) pol_inv_d = ~pol_inv_q;
            bit_cnt_d  = '0;
            word_cnt_d = WCW'(1);
            good_d     = GW'(1);
            miss_d     = '0;
            tout_d     = '0;
            state_d    = (VERIFY_CNT == 1) ? LOCKED : VERIFY;
          end else if (tout_q == TW'(HUNT_TIMEOUT - 1)) begin
            bias_sel_d = ~bias_sel_q;
            tout_d     = '0;
          end else begin
            tout_d = tout_q + 1'b1;
          end
        end
        VERIFY: begin
          if (boundary) begin
            word_cnt_d = word_cnt_inc;
            if (sync_slot) begin
              if (sync_match) begin
                good_d = good_inc;
                if (good_inc == GW'(VERIFY_CNT)) begin
                  state_d = LOCKED;
                  miss_d  = '0;
                end
              end else begin
                drop_hunt = 1'b1;
              end
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            word_cnt_d = word_cnt_inc;
            if (!sync_slot) begin
              word_out_d = sr_next;
              word_vld_d = 1'b1;
            end else if (sync_match) begin
              miss_d = '0;
            end else begin
              miss_d = miss_inc;
              if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
              if (miss_inc == MW'(LOSS_CNT)) drop_hunt = 1'b1;
            end
          end
        end
        default: drop_hunt = 1'b1;
      endcase
    end

    if (drop_hunt) begin
      state_d    = HUNT;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
      good_d     = '0;
      miss_d     = '0;
      tout_d     = '0;
    end

    if (clr_err) err_cnt_d = '0;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      sr_q       <= '0;
      word_out_q <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      good_q     <= '0;
      miss_q     <= '0;
      tout_q     <= '0;
      err_cnt_q  <= '0;
      word_vld_q <= 1'b0;
      locked_q   <= 1'b0;
      bias_sel_q <= 1'b0;
      pol_inv_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      word_out_q <= word_out_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      good_q     <= good_d;
      miss_q     <= miss_d;
      tout_q     <= tout_d;
      err_cnt_q  <= err_cnt_d;
      word_vld_q <= word_vld_d;
      locked_q   <= locked_d;
      bias_sel_q <= bias_sel_d;
      pol_inv_q  <= pol_inv_d;
    end
  end

  assign word_out = word_out_q;
  assign word_vld = word_vld_q;
  assign locked   = locked_q;
  assign bias_sel = bias_sel_q;
  assign pol_inv  = pol_inv_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Bench for rx_link_ctrl: table-driven frame vectors, hand sequences and random traffic against a bit-level model.
// Honours RX_LINK_AUTO_POL_EN to select the expected polarity behaviour.

module tb_rx_link_ctrl;

  localparam logic [15:0] SYNC = 16'hF628;
  localparam int FW = 8, VCNT = 3, LCNT = 2, HTO = 1024;
`ifdef RX_LINK_AUTO_POL_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, bit_in, bit_vld, clr_err;
  logic [15:0] word_out;
  logic        word_vld, locked, bias_sel, pol_inv;
  logic [7:0]  err_cnt;

  int n_checks = 0, n_pass = 0;
  int vld_seen = 0;
  bit lock_seen = 1'b0;
  bit gap_en = 1'b0, clr_rand_en = 1'b0;

  always #5 clk = ~clk;

  rx_link_ctrl dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .clr_err(clr_err),
    .word_out(word_out), .word_vld(word_vld), .locked(locked),
    .bias_sel(bias_sel), .pol_inv(pol_inv), .err_cnt(err_cnt)
  );

  // Reference model: alignment tracked as a bit position inside the frame
  int          m_mode;
  logic [15:0] m_sr, m_word;
  int          m_pos, m_good, m_miss, m_tout, m_err;
  logic        m_vld, m_bias, m_pol;

  function automatic void model_reset();
    m_mode = 0; m_sr = '0; m_word = '0; m_pos = 0; m_good = 0; m_miss = 0;
    m_tout = 0; m_err = 0; m_vld = 1'b0; m_bias = 1'b0; m_pol = 1'b0;
  endfunction

  function automatic void model_hunt();
    m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0; m_tout = 0;
  endfunction

  function automatic void model_step(input logic b, input logic vld, input logic clr);
    m_vld = 1'b0;
    if (vld) begin
      m_sr = {m_sr[14:0], b ^ m_pol};
      if (m_mode == 0) begin
        if (m_sr == SYNC || (AUTO && m_sr == ~SYNC)) begin
          if (m_sr != SYNC) m_pol = ~m_pol;
          m_pos = 0; m_good = 1; m_miss = 0; m_tout = 0;
          m_mode = (VCNT == 1) ? 2 : 1;
        end else begin
          m_tout++;
          if (m_tout == HTO) begin
            m_bias = ~m_bias;
            m_tout = 0;
          end
        end
      end else begin
        m_pos = (m_pos + 1) % (16 * FW);
        if (m_pos % 16 == 0) begin
          if (m_pos == 0) begin
            if (m_mode == 1) begin
              if (m_sr == SYNC) begin
                m_good++;
                if (m_good == VCNT) begin m_mode = 2; m_miss = 0; end
              end else model_hunt();
            end else begin
              if (m_sr == SYNC) m_miss = 0;
              else begin
                m_miss++;
                if (m_err < 255) m_err++;
                if (m_miss == LCNT) model_hunt();
              end
            end
          end else if (m_mode == 2) begin
            m_word = m_sr;
            m_vld  = 1'b1;
          end
        end
      end
    end
    if (clr) m_err = 0;
  endfunction

  function automatic logic safe_bit(input logic cand);
    logic [15:0] nx;
    nx = {m_sr[14:0], cand ^ m_pol};
    if (nx == SYNC || (AUTO && nx == ~SYNC)) return ~cand;
    return cand;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic compareModel();
    checkOutput("model_locked",   16'(locked),   16'(m_mode == 2));
    checkOutput("model_word_vld", 16'(word_vld), 16'(m_vld));
    checkOutput("model_word_out", word_out,      m_word);
    checkOutput("model_bias_sel", 16'(bias_sel), 16'(m_bias));
    checkOutput("model_pol_inv",  16'(pol_inv),  16'(m_pol));
    checkOutput("model_err_cnt",  16'(err_cnt),  16'(m_err));
  endtask

  task automatic applyStimulus(input logic b, input logic vld, input logic clr);
    @(negedge clk);
    bit_in = b; bit_vld = vld; clr_err = clr;
    @(posedge clk);
    model_step(b, vld, clr);
    #1;
    compareModel();
    if (word_vld) vld_seen++;
    if (locked) lock_seen = 1'b1;
  endtask

  task automatic sendBit(input logic b, input logic clr);
    if (gap_en && $urandom_range(0, 3) == 0)
      applyStimulus(1'($urandom), 1'b0, clr_rand_en && ($urandom_range(0, 31) == 0));
    applyStimulus(b, 1'b1, clr || (clr_rand_en && ($urandom_range(0, 63) == 0)));
  endtask

  task automatic sendWord(input logic [15:0] w, input logic clr_last);
    for (int i = 15; i >= 0; i--) sendBit(w[i], (i == 0) && clr_last);
  endtask

  task automatic sendFrame(input logic [15:0] s, input logic clr_sync, input logic inv);
    sendWord(s, clr_sync);
    for (int j = 1; j < FW; j++) sendWord(inv ? ~16'(j) : 16'(j), 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1; bit_in = 1'b0; bit_vld = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [15:0] word;
    logic        exp_locked;
    logic        exp_vld;
    logic [15:0] exp_word;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    // Lock-up, data, then one lone sync miss and two consecutive misses
    for (int k = 0; k <= 56; k++) begin
      bit bad;
      bad          = (k == 32 || k == 48 || k == 56);
      v.word       = (k % 8 == 0) ? (bad ? 16'h1234 : SYNC) : 16'(k % 8);
      v.exp_locked = (k >= 16 && k < 56);
      v.exp_vld    = (k > 16 && k < 56 && k % 8 != 0);
      v.exp_word   = (k <= 16) ? 16'h0 : ((k % 8 == 0) ? 16'h7 : 16'(k % 8));
      v.exp_err    = (k < 32) ? 8'd0 : (k < 48) ? 8'd1 : (k < 56) ? 8'd2 : 8'd3;
      vecs.push_back(v);
    end

    doReset();
    checkOutput("reset_locked",   16'(locked),   16'h0);
    checkOutput("reset_word_vld", 16'(word_vld), 16'h0);
    checkOutput("reset_word_out", word_out,      16'h0);
    checkOutput("reset_bias_sel", 16'(bias_sel), 16'h0);
    checkOutput("reset_pol_inv",  16'(pol_inv),  16'h0);
    checkOutput("reset_err_cnt",  16'(err_cnt),  16'h0);

    $display("[TB] hunt timeout on sync-free noise");
    gap_en = 1'b1; vld_seen = 0;
    for (int i = 0; i < HTO - 1; i++) sendBit(safe_bit(1'($urandom)), 1'b0);
    checkOutput("bias_before_timeout", 16'(bias_sel), 16'h0);
    checkOutput("noise_no_lock",       16'(locked),   16'h0);
    checkOutput("noise_no_word_vld",   16'(vld_seen), 16'h0);
    sendBit(safe_bit(1'($urandom)), 1'b0);
    checkOutput("bias_at_timeout", 16'(bias_sel), 16'h1);
    gap_en = 1'b0;

    $display("[TB] frame vector table");
    doReset();
    foreach (vecs[i]) begin
      sendWord(vecs[i].word, 1'b0);
      checkOutput($sformatf("vec%0d_locked", i),   16'(locked),   16'(vecs[i].exp_locked));
      checkOutput($sformatf("vec%0d_word_vld", i), 16'(word_vld), 16'(vecs[i].exp_vld));
      checkOutput($sformatf("vec%0d_word_out", i), word_out,      vecs[i].exp_word);
      checkOutput($sformatf("vec%0d_err_cnt", i),  16'(err_cnt),  16'(vecs[i].exp_err));
    end

    $display("[TB] bad second sync during verify");
    doReset();
    lock_seen = 1'b0;
    sendFrame(SYNC, 1'b0, 1'b0);
    sendWord(16'h0000, 1'b0);
    checkOutput("verify_fail_lock_seen", 16'(lock_seen), 16'h0);
    checkOutput("verify_fail_bias",      16'(bias_sel),  16'h0);
    for (int j = 1; j < FW; j++) sendWord(16'(j), 1'b0);
    sendFrame(SYNC, 1'b0, 1'b0);
    sendFrame(SYNC, 1'b0, 1'b0);
    checkOutput("rehunt_not_yet_locked", 16'(locked), 16'h0);
    sendWord(SYNC, 1'b0);
    checkOutput("rehunt_locked", 16'(locked), 16'h1);

    $display("[TB] err_cnt saturation and clear");
    doReset();
    repeat (3) sendFrame(SYNC, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) begin
      sendFrame(16'h0F0F, 1'b0, 1'b0);
      sendFrame(SYNC, 1'b0, 1'b0);
    end
    checkOutput("err_at_255", 16'(err_cnt), 16'd255);
    sendWord(16'h0F0F, 1'b0);
    checkOutput("err_saturated", 16'(err_cnt), 16'd255);
    checkOutput("sat_still_locked", 16'(locked), 16'h1);
    for (int j = 1; j < FW; j++) sendWord(16'(j), 1'b0);
    sendFrame(SYNC, 1'b0, 1'b0);
    sendWord(16'h0F0F, 1'b1);
    checkOutput("clr_beats_miss", 16'(err_cnt), 16'h0);
    checkOutput("clr_still_locked", 16'(locked), 16'h1);

    $display("[TB] asynchronous reset mid-word");
    doReset();
    repeat (3) sendFrame(SYNC, 1'b0, 1'b0);
    sendWord(16'h0F0F, 1'b0);
    for (int i = 15; i >= 8; i--) sendBit(1'b1, 1'b0);
    @(negedge clk);
    bit_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_locked",   16'(locked),  16'h0);
    checkOutput("async_rst_err",      16'(err_cnt), 16'h0);
    checkOutput("async_rst_word_out", word_out,     16'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vld_seen = 0;
    for (int i = 7; i >= 0; i--) sendBit(1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("no_partial_word", 16'(vld_seen), 16'h0);

    $display("[TB] random traffic against model");
    doReset();
    gap_en = 1'b1; clr_rand_en = 1'b1;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0, 1: sendFrame(SYNC, 1'b0, 1'b0);
        2:    sendFrame(16'($urandom), 1'b0, 1'b0);
        3:    for (int i = 0; i < 24; i++) sendBit(1'($urandom), 1'b0);
        4:    sendFrame(~SYNC, 1'b0, 1'b1);
        default: repeat ($urandom_range(1, 6)) applyStimulus(1'($urandom), 1'b0, 1'($urandom));
      endcase
    end
    gap_en = 1'b0; clr_rand_en = 1'b0;

    $display("[TB] inverted stream");
    doReset();
    sendWord(~SYNC, 1'b0);
    checkOutput("inv_pol_after_sync", 16'(pol_inv), 16'(AUTO));
    for (int j = 1; j < FW; j++) sendWord(~16'(j), 1'b0);
    repeat (3) sendFrame(~SYNC, 1'b0, 1'b1);
    checkOutput("inv_locked",   16'(locked),  16'(AUTO));
    checkOutput("inv_pol_inv",  16'(pol_inv), 16'(AUTO));
    checkOutput("inv_word_out", word_out,     AUTO ? 16'h0007 : 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
